// File: rtl/wave_oscillator_pkg.sv
// Shared types and default widths for the tone oscillator.
// Imported by the oscillator interface and the oscillator top.
package synth_pkg;

   localparam int WAVE_W_DEF = 8;
   localparam int DIV_W_DEF  = 10;

   typedef enum logic [1:0] {
      SAW      = 2'd0,
      SQUARE   = 2'd1,
      PULSE    = 2'd2,
      TRIANGLE = 2'd3
   } wave_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } osc_state_t;

endpackage

// File: rtl/wave_oscillator_if.sv
// Control and sample bundle between the voice controller and the oscillator.
// No handshake: controls are level-sampled every clock; step/wrap are one-cycle strobes with no backpressure.
interface wave_oscillator_if #(
   parameter int WAVE_W = 8,
   parameter int DIV_W  = 10
) ();
   import synth_pkg::*;

   logic              enable;
   logic [DIV_W-1:0]  note_div;
   logic [1:0]        oct_dwn;
   wave_mode_t        mode;
   logic [WAVE_W-1:0] duty;
   logic              sync;

   logic [WAVE_W-1:0] wave;
   logic              step;
   logic              wrap;
   logic              running;
   osc_state_t        dbg_state;

   modport master (
      output enable, note_div, oct_dwn, mode, duty, sync,
      input  wave, step, wrap, running, dbg_state
   );

   modport slave (
      input  enable, note_div, oct_dwn, mode, duty, sync,
      output wave, step, wrap, running, dbg_state
   );

endinterface

// File: rtl/wave_oscillator_prescaler.sv
// Period prescaler: holds the latched period and emits a tick every per_q cycles.
// The >= compare lets a shorter reloaded period take effect without a runaway count.
module osc_prescaler #(
   parameter int CNT_W = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_start,
   input  logic             i_restart,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_period,
   output logic             o_tick,
   output logic             o_step,
   output logic             o_per_zero
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_per_q;
   logic             r_step;

   assign o_tick     = i_run && !i_restart && (r_count >= r_per_q);
   assign o_per_zero = (r_per_q == '0);
   assign o_step     = r_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_per_q <= '0;
         r_step  <= 1'b0;
      end else begin
         if (i_load) begin
            r_per_q <= i_period;
         end
         if (i_start || i_restart || o_tick) begin
            r_count <= CNT_W'(1);
         end else if (i_run) begin
            r_count <= r_count + CNT_W'(1);
         end else begin
            r_count <= '0;
         end
         r_step <= o_tick;
      end
   end

endmodule

// File: rtl/wave_oscillator.sv
// Tone oscillator: IDLE/RUN control, phase accumulator, wrap detection and waveform shaping.
// Period is relatched only at wrap, sync or start so retuning never glitches mid-cycle.
module wave_oscillator
   import synth_pkg::*;
#(
   parameter int WAVE_W = WAVE_W_DEF,
   parameter int DIV_W  = DIV_W_DEF,
   parameter int CNT_W  = DIV_W + 3
) (
   input logic              clk,
   input logic              rst,
   wave_oscillator_if.slave bus
);

   localparam logic [WAVE_W-1:0] MAX = '1;

   osc_state_t        r_state;
   osc_state_t        w_state_nxt;
   logic [WAVE_W-1:0] r_phase;
   logic [WAVE_W-1:0] r_wave;
   logic              r_wrap;

   logic              w_start;
   logic              w_stay;
   logic              w_restart;
   logic              w_tick;
   logic              w_wrap_tick;
   logic              w_load;
   logic              w_step;
   logic              w_per_zero;
   logic [CNT_W-1:0]  w_period;

   function automatic logic [WAVE_W-1:0] shape(input logic [WAVE_W-1:0] ph,
                                               input wave_mode_t        m,
                                               input logic [WAVE_W-1:0] d);
      logic [WAVE_W-1:0] t;
      t = {ph[WAVE_W-2:0], 1'b0};
      case (m)
         SAW:     shape = ph;
         SQUARE:  shape = ph[WAVE_W-1] ? MAX : '0;
         PULSE:   shape = (ph < d) ? MAX : '0;
         default: shape = ph[WAVE_W-1] ? ~t : t;
      endcase
   endfunction

   assign w_period    = CNT_W'(bus.note_div) << bus.oct_dwn;
   assign w_wrap_tick = w_tick && (r_phase == MAX);
   assign w_load      = w_start || w_restart || w_wrap_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stay      = 1'b0;
      w_restart   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.enable && (bus.note_div != '0)) begin
               w_state_nxt = RUN;
               w_start     = 1'b1;
            end
         end
         RUN: begin
            if (!bus.enable || w_per_zero) begin
               w_state_nxt = IDLE;
            end else begin
               w_stay    = 1'b1;
               w_restart = bus.sync;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   osc_prescaler #(
      .CNT_W(CNT_W)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .i_run     (w_stay),
      .i_start   (w_start),
      .i_restart (w_restart),
      .i_load    (w_load),
      .i_period  (w_period),
      .o_tick    (w_tick),
      .o_step    (w_step),
      .o_per_zero(w_per_zero)
   );

   // Leaving RUN clears phase and wave on the same edge, so both read 0 next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
         r_wave  <= '0;
         r_wrap  <= 1'b0;
      end else begin
         if (!w_stay || w_restart) begin
            r_phase <= '0;
         end else if (w_tick) begin
            r_phase <= r_phase + WAVE_W'(1);
         end
         r_wave <= w_stay ? shape(r_phase, bus.mode, bus.duty) : '0;
         r_wrap <= w_wrap_tick;
      end
   end

   assign bus.wave      = r_wave;
   assign bus.step      = w_step;
   assign bus.wrap      = r_wrap;
   assign bus.running   = (r_state == RUN);
   assign bus.dbg_state = r_state;

endmodule
